// File: rtl/acc_track_scheduler.sv
// Per-track sequencer: tracks scan/track state, drives the flag generator enables, latches detect width per track.
// Define ACC_TRACK_TIMEOUT_EN to add an ARM/GAP wait timeout (timeout_cyc_i / timeout_err_o).
module acc_track_scheduler #(
  parameter int TRK_CNT_W = 16,
  parameter int SMP_CNT_W = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 laser_start_i,
  input  logic                 track_start_i,
  input  logic                 filter_vld_i,
  input  logic [SMP_CNT_W-1:0] track_len_i,
  input  logic [15:0]          warmup_len_i,
  input  logic [15:0]          detect_width_para_i,
`ifdef ACC_TRACK_TIMEOUT_EN
  input  logic [31:0]          timeout_cyc_i,
  output logic                 timeout_err_o,
`endif
  output logic                 filter_en_o,
  output logic                 first_track_ctrl_o,
  output logic                 second_track_en_o,
  output logic [15:0]          detect_width_para_o,
  output logic [TRK_CNT_W-1:0] track_idx_o,
  output logic [SMP_CNT_W-1:0] sample_cnt_o,
  output logic                 track_done_o,
  output logic                 overrun_err_o
);

  typedef enum logic [2:0] {IDLE, ARM, WARMUP, ACTIVE, GAP} state_t;

  state_t               state_q, state_d;
  logic [SMP_CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [TRK_CNT_W-1:0] track_idx_q, track_idx_d;
  logic [15:0]          width_q, width_d;
  logic                 overrun_q, overrun_d;
  logic                 done_d;
  logic                 filter_en_q, second_en_q, done_q;

  logic [SMP_CNT_W-1:0] smp_adv;
  logic [SMP_CNT_W-1:0] last_smp;
  logic [TRK_CNT_W-1:0] idx_inc;

`ifdef ACC_TRACK_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_err_q, tmo_err_d;
  logic        tmo_hit;
`endif

  // Saturating advances; a zero track length behaves like a one-sample track.
  assign smp_adv  = (filter_vld_i && (sample_cnt_q != '1)) ? sample_cnt_q + SMP_CNT_W'(1) : sample_cnt_q;
  assign last_smp = (track_len_i == '0) ? '0 : track_len_i - SMP_CNT_W'(1);
  assign idx_inc  = (track_idx_q != '1) ? track_idx_q + TRK_CNT_W'(1) : track_idx_q;

`ifdef ACC_TRACK_TIMEOUT_EN
  assign tmo_hit = (timeout_cyc_i != '0) && (({1'b0, tmo_cnt_q} + 33'd1) >= {1'b0, timeout_cyc_i});
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    track_idx_d  = track_idx_q;
    width_d      = width_q;
    overrun_d    = overrun_q;
    done_d       = 1'b0;
`ifdef ACC_TRACK_TIMEOUT_EN
    tmo_cnt_d    = '0;
    tmo_err_d    = tmo_err_q;
`endif
    if (!laser_start_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = ARM;
          track_idx_d = '0;
          overrun_d   = 1'b0;
`ifdef ACC_TRACK_TIMEOUT_EN
          tmo_err_d   = 1'b0;
`endif
        end
        ARM, GAP: begin
          if (track_start_i) begin
            state_d      = WARMUP;
            sample_cnt_d = '0;
            width_d      = detect_width_para_i;
            if (state_q == GAP) track_idx_d = idx_inc;
          end else begin
`ifdef ACC_TRACK_TIMEOUT_EN
            tmo_cnt_d = tmo_cnt_q + 32'd1;
            if (tmo_hit) begin
              state_d   = IDLE;
              tmo_err_d = 1'b1;
            end
`endif
          end
        end
        WARMUP, ACTIVE: begin
          if (track_start_i) begin
            // A new track overran the current one: flag it and restart warm-up.
            state_d      = WARMUP;
            sample_cnt_d = '0;
            width_d      = detect_width_para_i;
            track_idx_d  = idx_inc;
            overrun_d    = 1'b1;
          end else if (state_q == WARMUP) begin
            if (smp_adv >= SMP_CNT_W'(warmup_len_i)) begin
              state_d      = ACTIVE;
              sample_cnt_d = '0;
            end else begin
              sample_cnt_d = smp_adv;
            end
          end else begin
            sample_cnt_d = smp_adv;
            if (filter_vld_i && (sample_cnt_q == last_smp)) begin
              state_d = GAP;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state updates use non-blocking assignment so every register samples pre-edge values.
    if (rst_i) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      track_idx_q  <= '0;
      width_q      <= detect_width_para_i;
      overrun_q    <= 1'b0;
      filter_en_q  <= 1'b0;
      second_en_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      track_idx_q  <= track_idx_d;
      width_q      <= width_d;
      overrun_q    <= overrun_d;
      filter_en_q  <= (state_d == ACTIVE);
      second_en_q  <= (state_d != IDLE) && (track_idx_d != '0);
      done_q       <= done_d;
    end
  end

`ifdef ACC_TRACK_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeout_err_o = tmo_err_q;
`endif

  assign filter_en_o         = filter_en_q;
  assign first_track_ctrl_o  = (track_idx_q == '0) && (state_q inside {WARMUP, ACTIVE, GAP});
  assign second_track_en_o   = second_en_q;
  assign detect_width_para_o = width_q;
  assign track_idx_o         = track_idx_q;
  assign sample_cnt_o        = sample_cnt_q;
  assign track_done_o        = done_q;
  assign overrun_err_o       = overrun_q;

endmodule
